// File: rtl/alu_master.sv
// alu_master: initiator for the ALU ACT/RDY/VLD execution interface.
// Takes one operation from the sequencer, issues it to the ALU, collects one
// result beat (two for MUL, low word first) and presents a 64-bit result with
// an error flag downstream. One operation in flight at a time, no overlap.
module alu_master #(
  parameter int         TIMEOUT_CYCLES = 16,
  parameter logic [3:0] MUL_OP         = 4'b0010
) (
  input  logic        CLK,
  input  logic        RST,
  // upstream request channel
  input  logic        REQ_VLD,
  output logic        REQ_RDY,
  input  logic [3:0]  REQ_OP,
  input  logic [1:0]  REQ_MOVI,
  input  logic [31:0] REQ_A,
  input  logic [31:0] REQ_B,
  input  logic [31:0] REQ_MEM,
  input  logic [31:0] REQ_IMM,
  // ALU execution interface
  output logic        ALU_ACT,
  output logic [3:0]  ALU_OP,
  output logic [1:0]  ALU_MOVI,
  output logic [31:0] ALU_REG_A,
  output logic [31:0] ALU_REG_B,
  output logic [31:0] ALU_MEM,
  output logic [31:0] ALU_IMM,
  input  logic [31:0] ALU_DATA,
  input  logic        ALU_RDY,
  input  logic        ALU_VLD,
  // downstream result channel
  output logic        RES_VLD,
  input  logic        RES_RDY,
  output logic [63:0] RES_DATA,
  output logic        RES_WIDE,
  output logic        RES_ERR
);

  // Counter runs 0 .. TIMEOUT_CYCLES-1 across the no-VLD cycles of WAIT_LO.
  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
    HOLD
  } state_t;

  state_t           state_q, state_next;

  logic [3:0]       op_q;
  logic [1:0]       movi_q;
  logic [31:0]      a_q, b_q, mem_q, imm_q;
  logic [63:0]      res_data_q;
  logic             res_wide_q, res_err_q;
  logic [CNT_W-1:0] cnt_q;

  // Control strobes decoded from the current state for the datapath.
  logic accept, cnt_clr, cnt_inc, cap_lo, cap_hi, err_timeout, err_proto;

  // State register; a synchronous RST drops any transaction in flight.
  always_ff @(posedge CLK) begin
    // NOTE: clocked state is always written with <= so every register samples
    // pre-edge values regardless of statement order.
    if (RST) state_q <= IDLE;
    else     state_q <= state_next;
  end

  // Next-state, handshake outputs and datapath strobes.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave a value held and infer a latch.
    state_next  = state_q;
    REQ_RDY     = 1'b0;
    ALU_ACT     = 1'b0;
    RES_VLD     = 1'b0;
    accept      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    cap_lo      = 1'b0;
    cap_hi      = 1'b0;
    err_timeout = 1'b0;
    err_proto   = 1'b0;
    case (state_q)
      IDLE: begin
        REQ_RDY = 1'b1;
        if (REQ_VLD) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // ACT held until the ALU takes it; no timeout while the ALU is busy.
        ALU_ACT = 1'b1;
        if (ALU_RDY) begin
          cnt_clr    = 1'b1;
          state_next = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (ALU_VLD) begin
          cap_lo     = 1'b1;
          state_next = (op_q == MUL_OP) ? WAIT_HI : HOLD;
        end else if (cnt_q == CNT_LAST) begin
          err_timeout = 1'b1;
          state_next  = HOLD;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_HI: begin
        // The high beat must follow the low beat back to back.
        if (ALU_VLD) cap_hi    = 1'b1;
        else         err_proto = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        RES_VLD = 1'b1;
        if (RES_RDY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, result assembly and timeout counter.
  always_ff @(posedge CLK) begin
    // NOTE: operand and result registers are reset too, because the ALU_* and
    // RES_* outputs must read zero straight after reset.
    if (RST) begin
      op_q       <= '0;
      movi_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mem_q      <= '0;
      imm_q      <= '0;
      res_data_q <= '0;
      res_wide_q <= 1'b0;
      res_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (accept) begin
        op_q       <= REQ_OP;
        movi_q     <= REQ_MOVI;
        a_q        <= REQ_A;
        b_q        <= REQ_B;
        mem_q      <= REQ_MEM;
        imm_q      <= REQ_IMM;
        res_data_q <= '0;
        res_wide_q <= 1'b0;
        res_err_q  <= 1'b0;
      end
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
      if (cap_lo) begin
        res_data_q[31:0] <= ALU_DATA;
        if (op_q != MUL_OP) res_data_q[63:32] <= '0;
      end
      if (cap_hi) begin
        res_data_q[63:32] <= ALU_DATA;
        res_wide_q        <= 1'b1;
      end
      if (err_timeout) begin
        res_data_q <= '0;
        res_err_q  <= 1'b1;
      end
      if (err_proto) begin
        res_data_q <= '0;
        res_err_q  <= 1'b1;
        res_wide_q <= 1'b1;
      end
    end
  end

  assign ALU_OP    = op_q;
  assign ALU_MOVI  = movi_q;
  assign ALU_REG_A = a_q;
  assign ALU_REG_B = b_q;
  assign ALU_MEM   = mem_q;
  assign ALU_IMM   = imm_q;
  assign RES_DATA  = res_data_q;
  assign RES_WIDE  = res_wide_q;
  assign RES_ERR   = res_err_q;

endmodule

// File: tb/tb_alu_master.sv
// tb_alu_master: the bench plays sequencer, ALU and result consumer. Each
// transaction is planned up front (operands, ALU stall, result delay, dropped
// high beat, backpressure); the expected per-cycle timeline and result are
// derived from that plan and compared against the DUT on every cycle.
module tb_alu_master;

  localparam int         T   = 4;
  localparam logic [3:0] MUL = 4'b0010;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VLD, REQ_RDY;
  logic [3:0]  REQ_OP;
  logic [1:0]  REQ_MOVI;
  logic [31:0] REQ_A, REQ_B, REQ_MEM, REQ_IMM;
  logic        ALU_ACT;
  logic [3:0]  ALU_OP;
  logic [1:0]  ALU_MOVI;
  logic [31:0] ALU_REG_A, ALU_REG_B, ALU_MEM, ALU_IMM, ALU_DATA;
  logic        ALU_RDY, ALU_VLD;
  logic        RES_VLD, RES_RDY;
  logic [63:0] RES_DATA;
  logic        RES_WIDE, RES_ERR;

  always #5 CLK = ~CLK;

  alu_master #(.TIMEOUT_CYCLES(T), .MUL_OP(MUL)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VLD(REQ_VLD), .REQ_RDY(REQ_RDY), .REQ_OP(REQ_OP), .REQ_MOVI(REQ_MOVI),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_MEM(REQ_MEM), .REQ_IMM(REQ_IMM),
    .ALU_ACT(ALU_ACT), .ALU_OP(ALU_OP), .ALU_MOVI(ALU_MOVI),
    .ALU_REG_A(ALU_REG_A), .ALU_REG_B(ALU_REG_B), .ALU_MEM(ALU_MEM), .ALU_IMM(ALU_IMM),
    .ALU_DATA(ALU_DATA), .ALU_RDY(ALU_RDY), .ALU_VLD(ALU_VLD),
    .RES_VLD(RES_VLD), .RES_RDY(RES_RDY), .RES_DATA(RES_DATA),
    .RES_WIDE(RES_WIDE), .RES_ERR(RES_ERR)
  );

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  movi;
    logic [31:0] a, b, mem, imm;
    int          stall;    // cycles ALU_RDY stays low after ISSUE entry
    int          dly;      // low beat arrives in this WAIT_LO cycle; 0 = never
    bit          drop_hi;  // MUL only: no VLD on the high beat
    int          bp;       // cycles RES_RDY stays low in HOLD
    bit          pend;     // next request already waiting during HOLD
    int          gap;      // idle cycles before this request is offered
    bit          use_lit;
    logic [63:0] lit_data;
    logic [1:0]  lit_flags; // {err, wide}
    int          lit_lat;
    int          lit_act;
  } plan_t;

  plan_t plans[$];

  int vectors    = 0;
  int miscompares = 0;

  // expectations shared with the compare process
  bit          chk_on = 1'b0, chk_ops = 1'b0, chk_zero_res = 1'b0;
  logic        exp_rdy, exp_act, exp_vld, exp_wide, exp_err;
  logic [3:0]  exp_op;
  logic [1:0]  exp_movi;
  logic [31:0] exp_a, exp_b, exp_mem, exp_imm;
  logic [63:0] exp_data;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  function automatic logic [31:0] sel_b(input logic [1:0] movi, input logic [31:0] b,
                                        input logic [31:0] mem, input logic [31:0] imm);
    case (movi)
      2'b00:   return b;
      2'b01:   return mem;
      2'b10:   return imm;
      default: return 32'h0;
    endcase
  endfunction

  // The bench ALU: full 64-bit product for MUL, (a+b)^op for everything else.
  function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] bb);
    if (op == MUL) return {32'h0, a} * {32'h0, bb};
    return {32'h0, (a + bb) ^ {28'h0, op}};
  endfunction

  // {err, wide, data} the sequencer must receive for a plan.
  function automatic logic [65:0] expect_res(input plan_t p);
    logic [63:0] full;
    full = alu_ref(p.op, p.a, sel_b(p.movi, p.b, p.mem, p.imm));
    if (p.dly == 0)              return {1'b1, 1'b0, 64'h0};
    if (p.op == MUL && p.drop_hi) return {1'b1, 1'b1, 64'h0};
    if (p.op == MUL)             return {1'b0, 1'b1, full};
    return {1'b0, 1'b0, 32'h0, full[31:0]};
  endfunction

  // Cycle (counting the accept edge as 0) in which RES_VLD first appears.
  function automatic int latency(input plan_t p);
    if (p.dly == 0) return p.stall + 1 + T + 1;
    return p.stall + 1 + p.dly + ((p.op == MUL) ? 1 : 0) + 1;
  endfunction

  // Compare process: checks every cycle against the current expectations.
  always @(negedge CLK) begin
    if (chk_on) begin
      check("req_rdy", REQ_RDY, exp_rdy);
      check("alu_act", ALU_ACT, exp_act);
      check("res_vld", RES_VLD, exp_vld);
      if (chk_ops) begin
        check("alu_op",    ALU_OP,    exp_op);
        check("alu_movi",  ALU_MOVI,  exp_movi);
        check("alu_reg_a", ALU_REG_A, exp_a);
        check("alu_reg_b", ALU_REG_B, exp_b);
        check("alu_mem",   ALU_MEM,   exp_mem);
        check("alu_imm",   ALU_IMM,   exp_imm);
      end
      if (exp_vld) begin
        check("res_data", RES_DATA, exp_data);
        check("res_wide", RES_WIDE, exp_wide);
        check("res_err",  RES_ERR,  exp_err);
      end
      if (chk_zero_res) begin
        check("rst_res_data", RES_DATA, 64'h0);
        check("rst_res_wide", RES_WIDE, 1'b0);
        check("rst_res_err",  RES_ERR,  1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_rdy = 1'b1;
    exp_act = 1'b0;
    exp_vld = 1'b0;
  endtask

  task automatic set_ops_exp(input plan_t p);
    exp_op   = p.op;
    exp_movi = p.movi;
    exp_a    = p.a;
    exp_b    = p.b;
    exp_mem  = p.mem;
    exp_imm  = p.imm;
  endtask

  task automatic drive_req(input plan_t p);
    REQ_VLD  = 1'b1;
    REQ_OP   = p.op;
    REQ_MOVI = p.movi;
    REQ_A    = p.a;
    REQ_B    = p.b;
    REQ_MEM  = p.mem;
    REQ_IMM  = p.imm;
  endtask

  task automatic drive_garbage_req();
    REQ_VLD  = 1'($urandom % 2);
    REQ_OP   = 4'($urandom);
    REQ_MOVI = 2'($urandom);
    REQ_A    = $urandom;
    REQ_B    = $urandom;
    REQ_MEM  = $urandom;
    REQ_IMM  = $urandom;
  endtask

  // Entered at an idle cycle; returns at the idle cycle after the handshake.
  task automatic run_txn(input plan_t p, input plan_t nxt, input bit has_next);
    int          lat, klo, khi, act_cnt, first;
    logic [63:0] full_r, got_data;
    logic [1:0]  got_flags;
    logic [65:0] res;
    chk_zero_res = 1'b0;
    for (int g = 0; g < p.gap; g++) begin
      set_idle_exp();
      REQ_VLD = 1'b0;
      ALU_VLD = 1'($urandom % 2);
      ALU_RDY = 1'($urandom % 2);
      tick();
    end
    set_idle_exp();
    drive_req(p);
    tick();
    lat       = latency(p);
    klo       = (p.dly == 0) ? -1 : p.stall + 1 + p.dly;
    khi       = (p.op == MUL && p.dly != 0) ? klo + 1 : -1;
    res       = expect_res(p);
    act_cnt   = 0;
    first     = 0;
    got_data  = '0;
    got_flags = '0;
    set_ops_exp(p);
    for (int k = 1; k <= lat + p.bp; k++) begin
      exp_rdy = 1'b0;
      exp_act = (k <= p.stall + 1);
      exp_vld = (k >= lat);
      {exp_err, exp_wide, exp_data} = res;
      if (ALU_ACT) act_cnt++;
      if (RES_VLD && first == 0) first = k;
      if (k == lat) begin
        got_data  = RES_DATA;
        got_flags = {RES_ERR, RES_WIDE};
      end
      if (k <= p.stall)           ALU_RDY = 1'b0;
      else if (k == p.stall + 1)  ALU_RDY = 1'b1;
      else                        ALU_RDY = 1'($urandom % 2);
      full_r = alu_ref(ALU_OP, ALU_REG_A, sel_b(ALU_MOVI, ALU_REG_B, ALU_MEM, ALU_IMM));
      if (k > p.stall + 1 && k < lat) begin
        if (k == klo) begin
          ALU_VLD  = 1'b1;
          ALU_DATA = full_r[31:0];
        end else if (k == khi && !p.drop_hi) begin
          ALU_VLD  = 1'b1;
          ALU_DATA = full_r[63:32];
        end else begin
          ALU_VLD  = 1'b0;
          ALU_DATA = $urandom;
        end
      end else begin
        // VLD outside the wait states must be ignored
        ALU_VLD  = 1'($urandom % 2);
        ALU_DATA = $urandom;
      end
      RES_RDY = (k < lat) ? 1'($urandom % 2) : (k == lat + p.bp);
      if (k >= lat) begin
        if (p.pend && has_next) drive_req(nxt);
        else                    REQ_VLD = 1'b0;
      end else begin
        drive_garbage_req();
      end
      tick();
    end
    set_idle_exp();
    if (!(p.pend && has_next)) REQ_VLD = 1'b0;
    if (p.use_lit) begin
      check("lit_latency",  32'(first),   32'(p.lit_lat));
      check("lit_act_cnt",  32'(act_cnt), 32'(p.lit_act));
      check("lit_res_data", got_data,     p.lit_data);
      check("lit_err_wide", got_flags,    p.lit_flags);
    end
  endtask

  function automatic plan_t mk(input logic [3:0] op, input logic [1:0] movi,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] mem, input logic [31:0] imm,
                               input int stall, input int dly, input bit drop_hi,
                               input int bp, input bit pend);
    plan_t p;
    p.op = op; p.movi = movi; p.a = a; p.b = b; p.mem = mem; p.imm = imm;
    p.stall = stall; p.dly = dly; p.drop_hi = drop_hi; p.bp = bp; p.pend = pend;
    p.gap = 0; p.use_lit = 1'b0; p.lit_data = '0; p.lit_flags = '0;
    p.lit_lat = 0; p.lit_act = 0;
    return p;
  endfunction

  function automatic plan_t lit(input plan_t p, input logic [63:0] d,
                                input logic [1:0] flags, input int lat, input int act);
    plan_t q;
    q = p;
    q.use_lit = 1'b1; q.lit_data = d; q.lit_flags = flags;
    q.lit_lat = lat;  q.lit_act = act;
    return q;
  endfunction

  initial begin
    plan_t p, none, m;
    logic [63:0] full_r;

    // hand-computed directed transactions
    plans.push_back(lit(mk(4'h0, 2'b00, 32'd5, 32'd7, 32'h0, 32'h0, 0, 1, 0, 0, 0),
                        64'h0000_0000_0000_000C, 2'b00, 3, 1));
    plans.push_back(lit(mk(MUL, 2'b10, 32'hFFFF_FFFF, 32'h1234, 32'h55, 32'd2, 0, 1, 0, 0, 0),
                        64'h0000_0001_FFFF_FFFE, 2'b01, 4, 1));
    plans.push_back(lit(mk(4'h0, 2'b00, 32'd100, 32'd23, 32'h0, 32'h0, 5, 1, 0, 0, 0),
                        64'd123, 2'b00, 8, 6));
    plans.push_back(lit(mk(4'h0, 2'b00, 32'd1, 32'd1, 32'h0, 32'h0, 0, 0, 0, 0, 0),
                        64'h0, 2'b10, 6, 1));
    plans.push_back(lit(mk(MUL, 2'b00, 32'd3, 32'd4, 32'h0, 32'h0, 0, 1, 1, 0, 0),
                        64'h0, 2'b11, 4, 1));
    plans.push_back(lit(mk(4'h0, 2'b01, 32'd9, 32'd1, 32'h20, 32'h0, 0, 1, 0, 10, 1),
                        64'h29, 2'b00, 3, 1));
    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      p = mk(($urandom % 3 == 0) ? MUL : 4'($urandom), 2'($urandom),
             $urandom, $urandom, $urandom, $urandom,
             ($urandom % 5 == 0) ? 3 + int'($urandom % 4) : int'($urandom % 3),
             ($urandom % 6 == 0) ? 0 : 1 + int'($urandom % T),
             ($urandom % 5 == 0), int'($urandom % 4), ($urandom % 2 == 1));
      p.gap = int'($urandom % 3);
      plans.push_back(p);
    end
    for (int i = 1; i < plans.size(); i++)
      if (plans[i-1].pend) plans[i].gap = 0;

    // reset
    RST = 1'b1; REQ_VLD = 1'b0; REQ_OP = '0; REQ_MOVI = '0; REQ_A = '0; REQ_B = '0;
    REQ_MEM = '0; REQ_IMM = '0; ALU_DATA = '0; ALU_RDY = 1'b0; ALU_VLD = 1'b0; RES_RDY = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    set_idle_exp();
    set_ops_exp(mk(4'h0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0));
    chk_ops = 1'b1; chk_zero_res = 1'b1; chk_on = 1'b1;
    tick();
    chk_zero_res = 1'b0;

    none = mk(4'h0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 0, 0, 0);
    for (int i = 0; i < plans.size(); i++)
      run_txn(plans[i], (i + 1 < plans.size()) ? plans[i+1] : none, (i + 1 < plans.size()));

    // reset while the DUT waits for the MUL high beat
    m = mk(MUL, 2'b00, 32'd3, 32'd5, 32'h0, 32'h0, 0, 1, 0, 0, 0);
    set_idle_exp();
    drive_req(m);
    tick();
    set_ops_exp(m);
    exp_rdy = 1'b0; exp_act = 1'b1; exp_vld = 1'b0;
    REQ_VLD = 1'b0; ALU_RDY = 1'b1; ALU_VLD = 1'b0;
    tick();
    exp_act = 1'b0;
    full_r  = alu_ref(ALU_OP, ALU_REG_A, sel_b(ALU_MOVI, ALU_REG_B, ALU_MEM, ALU_IMM));
    ALU_VLD = 1'b1; ALU_DATA = full_r[31:0];
    tick();
    RST = 1'b1; ALU_VLD = 1'b1; ALU_DATA = full_r[63:32];
    tick();
    RST = 1'b0; ALU_VLD = 1'b0;
    set_idle_exp();
    set_ops_exp(mk(4'h0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0));
    chk_zero_res = 1'b1;
    tick();
    chk_zero_res = 1'b0;
    run_txn(lit(mk(4'h0, 2'b00, 32'd1, 32'd1, 32'h0, 32'h0, 0, 1, 0, 0, 0),
                64'd2, 2'b00, 3, 1), none, 1'b0);
    tick();
    chk_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_master.md
Name: alu_master

Overview:
- Initiator for the ALU ACT/RDY/VLD execution interface.
- Accepts one operation request from an upstream valid/ready channel and drives it into the ALU.
- Collects the result beats: one 32-bit beat for normal ops; two beats for MUL, low word then high word.
- Presents a single 64-bit result with error flag on a downstream valid/ready channel. Sits between the instruction sequencer and the ALU.

Parameters:
TIMEOUT_CYCLES, 16, max cycles waited in WAIT_LO for ALU_VLD before aborting with error (>=1)
MUL_OP, 4'b0010, OP encoding that returns two result beats

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
REQ_VLD  in  1  upstream request valid
REQ_RDY  out  1  upstream request ready
REQ_OP  in  4  operation code
REQ_MOVI  in  2  operand-B select (00 REG_B, 01 MEM, 10 IMM, 11 zero)
REQ_A  in  32  operand A
REQ_B  in  32  register operand B
REQ_MEM  in  32  memory operand
REQ_IMM  in  32  immediate operand
ALU_ACT  out  1  start request to ALU
ALU_OP  out  4  latched OP
ALU_MOVI  out  2  latched MOVI
ALU_REG_A  out  32  latched A
ALU_REG_B  out  32  latched B
ALU_MEM  out  32  latched MEM
ALU_IMM  out  32  latched IMM
ALU_DATA  in  32  ALU result beat
ALU_RDY  in  1  ALU idle / able to accept ACT
ALU_VLD  in  1  ALU result beat valid
RES_VLD  out  1  result valid
RES_RDY  in  1  downstream ready
RES_DATA  out  64  result; upper 32 zero for non-MUL
RES_WIDE  out  1  result came from MUL (two beats)
RES_ERR  out  1  timeout or protocol error; RES_DATA=0 when set

Behaviour:
- States: IDLE, ISSUE, WAIT_LO, WAIT_HI, HOLD.
- Reset (synchronous, RST high at edge): state=IDLE, all request/result registers=0, timeout counter=0.
  - Outputs after reset: REQ_RDY=1, ALU_ACT=0, all ALU_* operand outputs=0, RES_VLD=0, RES_DATA=0, RES_WIDE=0, RES_ERR=0.
  - Reset mid-operation abandons the transaction; no result is produced.
- IDLE: REQ_RDY=1 (REQ_RDY is high only in IDLE). On REQ_VLD&REQ_RDY: latch OP/MOVI/A/B/MEM/IMM, clear RES_ERR/RES_WIDE/result, go ISSUE.
- ALU_* operand outputs are driven from the latched registers. They hold stable from ISSUE through the last result beat and change only on the next accept.
- ISSUE: ALU_ACT=1, combinational from state.
  - Edge with ALU_RDY=1: ALU has accepted; go WAIT_LO, counter=0.
  - ALU_RDY=0: stay in ISSUE with ACT held, no timeout applied.
- WAIT_LO: ALU_ACT=0.
  - ALU_VLD=1: capture ALU_DATA into RES_DATA[31:0]. If latched OP==MUL_OP, go WAIT_HI; else set RES_DATA[63:32]=0 and go HOLD.
  - ALU_VLD=0: increment counter. When counter reaches TIMEOUT_CYCLES, set RES_ERR=1, RES_DATA=0, go HOLD.
- WAIT_HI: ALU_VLD is required high in this cycle, the cycle immediately after the low beat.
  - ALU_VLD=1: capture ALU_DATA into RES_DATA[63:32], RES_WIDE=1, go HOLD.
  - ALU_VLD=0: protocol error; RES_ERR=1, RES_DATA=0, RES_WIDE=1, go HOLD.
- HOLD: RES_VLD=1; RES_DATA/RES_WIDE/RES_ERR stable. On RES_RDY=1 at edge go IDLE; otherwise hold indefinitely (backpressure).
- ALU_VLD outside WAIT_LO/WAIT_HI is ignored.
- Latency with ALU_RDY=1 and RES_RDY=1, accept at edge 0:
  - ACT during cycle 1.
  - Non-MUL: RES_VLD during cycle 3, next REQ_RDY in cycle 4.
  - MUL: RES_VLD during cycle 4.
  - Throughput is one op per 4 (5 for MUL) cycles. There is no overlap: REQ_RDY stays 0 while HOLD waits for RES_RDY.
- RES_VLD is a registered output (state==HOLD); REQ_RDY=(state==IDLE).

Test Plan:
- Add: REQ_OP=0000, MOVI=00, A=5, B=7; ALU model returns 0x0000000C one cycle after ACT accepted -> ACT high exactly one cycle; RES_VLD in cycle 3 after accept; RES_DATA=0x000000000000000C, WIDE=0, ERR=0.
- MUL: OP=0010, A=0xFFFFFFFF, IMM=2, MOVI=10; ALU beats 0xFFFFFFFE then 0x00000001 -> RES_DATA=0x00000001FFFFFFFE, WIDE=1, RES_VLD in cycle 4; ALU_MOVI=10 and ALU_IMM=2 stable through both beats.
- ALU stall: hold ALU_RDY=0 for 5 cycles after ISSUE entry -> ALU_ACT high for 6 consecutive cycles, no ERR; result follows normally after ALU_RDY rises.
- Timeout: TIMEOUT_CYCLES=4, ALU never asserts VLD after accept -> RES_VLD with ERR=1, RES_DATA=0 after 4 WAIT_LO cycles. MUL with VLD dropped on the second beat -> ERR=1, WIDE=1.
- Backpressure: RES_RDY=0 for 10 cycles in HOLD -> RES_VLD/RES_DATA stable, REQ_RDY=0 throughout, a pending REQ_VLD is not accepted; accepted in the cycle after the RES_RDY handshake.
- Reset mid-op: assert RST in WAIT_HI -> next cycle state IDLE, REQ_RDY=1, RES_VLD=0, RES_DATA=0, ALU_ACT=0; a subsequent add 1+1 returns 2 correctly.
